// File: rtl/seqmul8su_ctrl_if.sv
// -----------------------------------------------------------------------------
// seqmul8su_ctrl_if
//   Bundles the operand stream, the result stream and the shared 4x4 core
//   lanes of the iterative 8x8 signed x unsigned multiplier controller.
//
//   Operand stream : in_valid, in_ready, in_s[7:0] (signed), in_u[7:0] (unsigned)
//   Result stream  : out_valid, out_ready, out_p[15:0] (signed)
//   Core lanes     : mul_s[3:0] (signed nibble), mul_u[3:0] (unsigned nibble),
//                    mul_p[7:0] (signed product returned by the core)
//
//   master : the controller's view (drives in_ready, mul_s/mul_u, out_*)
//   slave  : the surrounding datapath's view (operand source, core, consumer)
// -----------------------------------------------------------------------------
interface seqmul8su_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_s;
    logic [7:0]  in_u;
    logic [3:0]  mul_s;
    logic [3:0]  mul_u;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;

    modport master (
        input  in_valid, in_s, in_u, mul_p, out_ready,
        output in_ready, mul_s, mul_u, out_valid, out_p
    );

    modport slave (
        output in_valid, in_s, in_u, mul_p, out_ready,
        input  in_ready, mul_s, mul_u, out_valid, out_p
    );
endinterface

// File: rtl/seqmul8su_ctrl.sv
// -----------------------------------------------------------------------------
// seqmul8su_ctrl
//   Iterative 8x8 signed x unsigned multiplier controller. One operand pair is
//   split into nibbles and pushed through an external, fully pipelined 4x4
//   signed x unsigned core in four passes; the returned partial products are
//   corrected, shifted and accumulated into a 16-bit signed result.
//
//   Parameters
//     CORE_LAT : cycles from mul_s/mul_u presentation to a valid mul_p (0..2)
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous, active-high reset
//     bus : seqmul8su_ctrl_if.master (operand stream, result stream, core lanes)
//
//   Build option
//     SEQMUL_ZERO_SKIP_EN : when defined, steps whose s or u nibble is zero are
//                           not issued; the remaining steps issue back-to-back.
//                           Undefined (default): all four steps always issue.
// -----------------------------------------------------------------------------
module seqmul8su_ctrl #(
    parameter int CORE_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    seqmul8su_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Travels alongside the core pipeline so each returning product knows how
    // to be corrected and where it lands in the accumulator.
    typedef struct packed {
        logic       valid;
        logic       last;   // final issued step of this operation
        logic       lo;     // step uses s_lo (needs the unsigned correction)
        logic [3:0] u_nib;  // u nibble used by the step
        logic [3:0] shift;  // 0, 4 or 8
    } tag_t;

    state_t      r_state;
    logic [7:0]  r_s;
    logic [7:0]  r_u;
    logic [15:0] r_acc;
    logic [3:0]  r_pending;     // steps still to be presented, bit n = step n
    tag_t        r_tag [0:CORE_LAT];
    logic        r_in_ready;
    logic        r_out_valid;
    logic [15:0] r_out_p;
    logic [3:0]  r_mul_s;
    logic [3:0]  r_mul_u;

    logic        w_accept;
    logic [3:0]  w_mask_in;
    logic [3:0]  w_pend;
    logic [7:0]  w_src_s;
    logic [7:0]  w_src_u;
    logic [1:0]  w_step;
    logic        w_has_step;
    logic [3:0]  w_rest;
    logic [3:0]  w_nib_s;
    logic [3:0]  w_nib_u;
    tag_t        w_issue_tag;
    tag_t        w_cap;
    logic [15:0] w_corr;
    logic [15:0] w_term;
    logic [15:0] w_term_sh;
    logic [15:0] w_acc_next;
    logic        w_cap_last;

    assign w_accept = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;

    // Step n pairs s nibble n[1] with u nibble n[0]:
    // step0 (s_lo,u_lo), step1 (s_lo,u_hi), step2 (s_hi,u_lo), step3 (s_hi,u_hi).
`ifdef SEQMUL_ZERO_SKIP_EN
    assign w_mask_in = {(|bus.in_s[7:4]) & (|bus.in_u[7:4]),
                        (|bus.in_s[7:4]) & (|bus.in_u[3:0]),
                        (|bus.in_s[3:0]) & (|bus.in_u[7:4]),
                        (|bus.in_s[3:0]) & (|bus.in_u[3:0])};
`else
    assign w_mask_in = 4'hF;
`endif

    // In IDLE the first step is built straight from the incoming operands so it
    // can be presented in the cycle right after the handshake.
    assign w_pend  = (r_state == ST_IDLE) ? w_mask_in : r_pending;
    assign w_src_s = (r_state == ST_IDLE) ? bus.in_s  : r_s;
    assign w_src_u = (r_state == ST_IDLE) ? bus.in_u  : r_u;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_step = 2'd3;
        if (w_pend[0])      w_step = 2'd0;
        else if (w_pend[1]) w_step = 2'd1;
        else if (w_pend[2]) w_step = 2'd2;
    end

    assign w_has_step = |w_pend;
    assign w_rest     = w_pend & ~(4'b0001 << w_step);
    assign w_nib_s    = w_step[1] ? w_src_s[7:4] : w_src_s[3:0];
    assign w_nib_u    = w_step[0] ? w_src_u[7:4] : w_src_u[3:0];

    always_comb begin
        w_issue_tag       = '0;
        w_issue_tag.valid = 1'b1;
        w_issue_tag.last  = ~|w_rest;
        w_issue_tag.lo    = ~w_step[1];
        w_issue_tag.u_nib = w_nib_u;
        // shift = 4 * (number of high nibbles in the step)
        w_issue_tag.shift = {w_step[1] & w_step[0], w_step[1] ^ w_step[0], 2'b00};
    end

    // Product leaving the core this cycle.
    assign w_cap      = r_tag[CORE_LAT];
    assign w_cap_last = w_cap.valid && w_cap.last;

    // The core reads s_lo as signed; when its MSB is set the true unsigned value
    // is 16 larger, so the product is short by 16*u_nib.
    assign w_corr     = (w_cap.lo && r_s[3]) ? {8'd0, w_cap.u_nib, 4'd0} : 16'd0;
    assign w_term     = {{8{bus.mul_p[7]}}, bus.mul_p} + w_corr;
    assign w_term_sh  = w_term << w_cap.shift;
    assign w_acc_next = r_acc + w_term_sh;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_u         <= '0;
            r_acc       <= '0;
            r_pending   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_mul_s     <= '0;
            r_mul_u     <= '0;
            // NOTE: the tag delay line is reset too; its valid bits are what
            // make core products still in flight across a reset get discarded.
            for (int k = 0; k <= CORE_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= CORE_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end

            // Nothing presented to the core unless a step is issued below.
            r_tag[0] <= '0;
            r_mul_s  <= '0;
            r_mul_u  <= '0;

            if (w_cap.valid) begin
                r_acc <= w_acc_next;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_s        <= bus.in_s;
                        r_u        <= bus.in_u;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_pending  <= w_rest;
                        if (w_has_step) begin
                            r_tag[0] <= w_issue_tag;
                            r_mul_s  <= w_nib_s;
                            r_mul_u  <= w_nib_u;
                            r_state  <= ST_ISSUE;
                        end else begin
                            // Every step skipped: the product is zero.
                            r_out_p     <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (w_has_step) begin
                        r_tag[0]  <= w_issue_tag;
                        r_mul_s   <= w_nib_s;
                        r_mul_u   <= w_nib_u;
                        r_pending <= w_rest;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                    // With CORE_LAT=0 the last product returns in its own
                    // issue cycle, so DRAIN is skipped entirely.
                    if (w_cap_last) begin
                        r_out_p     <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DRAIN: begin
                    if (w_cap_last) begin
                        r_out_p     <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_out_p;
    assign bus.mul_s     = r_mul_s;
    assign bus.mul_u     = r_mul_u;

endmodule

// File: doc/seqmul8su_ctrl.md
Name: seqmul8su_ctrl

Overview:
- Iterative 8x8 signed x unsigned multiplier controller. Time-shares one external 4x4 signed x unsigned core (mul_s signed, mul_u unsigned, mul_p 8-bit signed product) over four nibble passes.
- Accumulates the 16-bit signed result.
- Sits between a valid/ready operand stream and the shared core. Use case: area-constrained MAC datapaths that cannot afford a full 8x8 array.

Parameters:
- CORE_LAT, 0, cycles from mul_s/mul_u presentation to a valid mul_p. Legal values 0..2; the core is fully pipelined.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- in_s  in  8  signed multiplicand
- in_u  in  8  unsigned multiplier
- mul_s  out  4  signed nibble to core
- mul_u  out  4  unsigned nibble to core
- mul_p  in  8  signed core product
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  16  signed product in_s*in_u

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_p=0, mul_s=0, mul_u=0, FSM=IDLE, accumulator=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready at cycle T: register in_s/in_u, clear accumulator, go to ISSUE.
  - ISSUE: one step issued per cycle, starting at T+1, in fixed order:
    - step0 (s_lo, u_lo, shift 0)
    - step1 (s_lo, u_hi, shift 4)
    - step2 (s_hi, u_lo, shift 4)
    - step3 (s_hi, u_hi, shift 8)
    - After the last issue, go to DRAIN.
  - DRAIN: wait CORE_LAT cycles for in-flight products. Go to DONE when the last product has been captured; with CORE_LAT=0 this is the same cycle.
  - DONE: out_valid=1, out_p holds the final accumulator. On out_ready, go to IDLE next cycle.
- in_ready=0 in every state except IDLE. A new operand is never accepted in the same cycle as the result handshake.
- Capture of each issued step: product tag (shift, lo-flag, u nibble) travels through a CORE_LAT-deep delay line alongside the core. At capture, term = sext16(mul_p).
- Low-nibble correction: s_lo is unsigned but the core treats it as signed. For steps 0 and 1, when s_lo[3]=1, add (u_nibble<<4) to the term before shifting.
- Accumulation: accumulator += term << shift, in 16-bit two's complement. Overflow is impossible; final range is -32640..32385.
- Latency without skip: out_valid rises at T+5+CORE_LAT.
- mul_s/mul_u: drive the issued nibbles during issue cycles and hold 0 otherwise.
- out_valid&!out_ready: out_p and out_valid hold stable indefinitely.
- in_valid while busy: ignored; the source must hold it.
- rst asserted in any state, including with products in flight: everything returns to reset values next cycle. In-flight core products arriving after reset are discarded; the delay-line valid bits are cleared.

Optional Feature:
- Macro: SEQMUL_ZERO_SKIP_EN.
- Defined:
  - A step whose s nibble or u nibble is zero is not issued.
  - Remaining steps issue back-to-back in the same order.
  - With n issued steps: out_valid at T+1+n+CORE_LAT for n>0. If n=0, go straight to DONE with out_p=0, out_valid at T+1.
  - mul_s/mul_u stay 0 on skipped steps.
- Undefined: all four steps are always issued, and latency is fixed at T+5+CORE_LAT.

Test Plan:
- CORE_LAT=0, in_s=0x80 (-128), in_u=0xFF, out_ready=1 -> out_p=0x8080 (-32640), out_valid exactly at T+5, in_ready low T+1..T+5.
- CORE_LAT=2, in_s=0x7F, in_u=0xFF -> out_p=0x7E81 (32385) at T+7. Also in_s=0xFF, in_u=0x01 -> out_p=0xFFFF.
- Low-nibble correction: in_s=0x0F, in_u=0x0A -> out_p=0x0096 (150). Step0 sees mul_s=0xF, mul_u=0xA, mul_p=0xF6.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_p stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: rst pulsed at T+2 with CORE_LAT=1 -> next cycle out_valid=0, in_ready=1. A following op in_s=0x03, in_u=0x05 yields 0x000F with no corruption from the discarded product.
- With SEQMUL_ZERO_SKIP_EN, CORE_LAT=0:
  - in_s=0x00 -> out_p=0 at T+1.
  - in_s=0x30, in_u=0x02 -> one step issued, out_p=0x0060 at T+2.
  - Without the macro, both cases complete at T+5.
